// File: rtl/floor_request_server_if.sv
`default_nettype none
// ============================================================================
// Module      : floor_request_server_if
// Description : Bundle between the button latch block and the collective car
//               controller: latched request levels in, one-hot clear pulses
//               and car status out.
// Revision    : 1.0 - initial release
// ============================================================================
interface floor_request_server_if #(
    parameter int BUTTONS_WIDTH = 8,
    parameter int FLOOR_BITS    = 3
);
    logic [BUTTONS_WIDTH-1:0] active_in_levels;
    logic [BUTTONS_WIDTH-1:0] active_out_up_levels;
    logic [BUTTONS_WIDTH-1:0] active_out_down_levels;
    logic [BUTTONS_WIDTH-1:0] inactivate_in_levels;
    logic [BUTTONS_WIDTH-1:0] inactivate_out_up_levels;
    logic [BUTTONS_WIDTH-1:0] inactivate_out_down_levels;
    logic [FLOOR_BITS-1:0]    current_floor;
    logic                     direction;
    logic                     moving;
    logic                     door_open;

    // Latch side: owns the request levels, consumes clears and status.
    modport master (
        output active_in_levels, active_out_up_levels, active_out_down_levels,
        input  inactivate_in_levels, inactivate_out_up_levels,
               inactivate_out_down_levels, current_floor, direction, moving,
               door_open
    );

    // Controller side.
    modport slave (
        input  active_in_levels, active_out_up_levels, active_out_down_levels,
        output inactivate_in_levels, inactivate_out_up_levels,
               inactivate_out_down_levels, current_floor, direction, moving,
               door_open
    );
endinterface
`default_nettype wire

// File: rtl/floor_request_server.sv
`default_nettype none
// ============================================================================
// Module      : floor_request_server
// Description : Collective (SCAN) car controller. Reads latched requests,
//               moves the car one floor per MOVE_CYCLES clocks, opens the door
//               for DOOR_CYCLES clocks and returns one-cycle clear pulses for
//               the requests it serves.
//               Optional macro DOOR_HOLD_EN adds a door_hold input that keeps
//               the door open and restarts the door count on release.
// Revision    : 1.0 - initial release
// ============================================================================
module floor_request_server #(
    parameter int BUTTONS_WIDTH = 8,
    parameter int FLOOR_BITS    = 3,
    parameter int MOVE_CYCLES   = 16,
    parameter int DOOR_CYCLES   = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
`ifdef DOOR_HOLD_EN
    input  wire logic             door_hold,
`endif
    floor_request_server_if.slave bus
);
    localparam logic [FLOOR_BITS-1:0] c_TOP_FLOOR = FLOOR_BITS'(BUTTONS_WIDTH - 1);
    localparam logic [15:0]           c_MOVE_LAST = 16'(MOVE_CYCLES - 1);
    localparam logic [15:0]           c_DOOR_LAST = 16'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MOVING = 2'd1,
        S_DOOR   = 2'd2
    } state_t;

    state_t                   r_state, w_nxt_state;
    logic [FLOOR_BITS-1:0]    r_floor, w_nxt_floor, w_step_floor, w_eval_floor;
    logic                     r_dir, w_nxt_dir;
    logic [15:0]              r_mcnt, w_nxt_mcnt;
    logic [15:0]              r_dcnt, w_nxt_dcnt;
    logic                     r_clr_up, w_nxt_clr_up;
    logic                     r_clr_dn, w_nxt_clr_dn;
    logic [BUTTONS_WIDTH-1:0] r_pin, w_nxt_pin;
    logic [BUTTONS_WIDTH-1:0] r_pup, w_nxt_pup;
    logic [BUTTONS_WIDTH-1:0] r_pdn, w_nxt_pdn;

    logic [BUTTONS_WIDTH-1:0] w_req;
    logic [BUTTONS_WIDTH-1:0] w_onehot;
    logic                     w_above, w_below;
    logic                     w_in_f, w_up_f, w_dn_f, w_req_f;
    logic                     w_here_up, w_here_dn;
    logic                     w_at_top, w_at_bot;
    logic                     w_ahead, w_stop, w_enter_door, w_hold;
    logic                     w_entry_dir, w_entry_clr_up, w_entry_clr_dn;

`ifdef DOOR_HOLD_EN
    assign w_hold = door_hold;
`else
    assign w_hold = 1'b0;
`endif

    assign w_req = bus.active_in_levels | bus.active_out_up_levels
                 | bus.active_out_down_levels;

    // While travelling, every decision is taken against the floor being
    // arrived at; otherwise against the floor the car stands on.
    assign w_step_floor = r_dir ? (r_floor + FLOOR_BITS'(1)) : (r_floor - FLOOR_BITS'(1));
    assign w_eval_floor = (r_state == S_MOVING) ? w_step_floor : r_floor;

    // Floor decode and "any request above / below" of the evaluated floor.
    always_comb begin
        w_onehot = '0;
        w_above  = 1'b0;
        w_below  = 1'b0;
        for (int i = 0; i < BUTTONS_WIDTH; i++) begin
            if (i == int'(w_eval_floor)) w_onehot[i] = 1'b1;
            if (i >  int'(w_eval_floor)) w_above = w_above | w_req[i];
            if (i <  int'(w_eval_floor)) w_below = w_below | w_req[i];
        end
    end

    assign w_in_f    = |(bus.active_in_levels       & w_onehot);
    assign w_up_f    = |(bus.active_out_up_levels   & w_onehot);
    assign w_dn_f    = |(bus.active_out_down_levels & w_onehot);
    assign w_req_f   = w_in_f | w_up_f | w_dn_f;
    assign w_here_up = w_in_f | w_up_f;
    assign w_here_dn = w_in_f | w_dn_f;
    assign w_at_top  = (w_eval_floor == c_TOP_FLOOR);
    assign w_at_bot  = (w_eval_floor == '0);
    assign w_ahead   = r_dir ? w_above : w_below;

    // Arrival stop rule; the end floors always stop the car.
    assign w_stop = w_at_top | w_at_bot
                  | (r_dir ? (w_here_up | (~w_above & w_req_f))
                           : (w_here_dn | (~w_below & w_req_f)));

    // Door entry: the travel-direction hall class is always cleared; with
    // nothing ahead the car turns round and the opposite class is cleared too.
    assign w_entry_clr_up = r_dir  | ~w_ahead;
    assign w_entry_clr_dn = ~r_dir | ~w_ahead;
    assign w_entry_dir    = w_at_bot ? 1'b1 :
                            w_at_top ? 1'b0 :
                            (w_ahead ? r_dir : ~r_dir);

    // Next-state and next-value logic for the controller.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_floor  = r_floor;
        w_nxt_dir    = r_dir;
        w_nxt_mcnt   = r_mcnt;
        w_nxt_dcnt   = r_dcnt;
        w_nxt_clr_up = r_clr_up;
        w_nxt_clr_dn = r_clr_dn;
        w_nxt_pin    = '0;
        w_nxt_pup    = '0;
        w_nxt_pdn    = '0;
        w_enter_door = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_here_up | w_here_dn) begin
                    w_enter_door = 1'b1;
                end else if (w_ahead) begin
                    w_nxt_state = S_MOVING;
                    w_nxt_mcnt  = '0;
                end else if (r_dir ? w_below : w_above) begin
                    w_nxt_state = S_MOVING;
                    w_nxt_mcnt  = '0;
                    w_nxt_dir   = ~r_dir;
                end
            end
            S_MOVING: begin
                if (r_mcnt == c_MOVE_LAST) begin
                    w_nxt_floor = w_step_floor;
                    if (w_stop) w_enter_door = 1'b1;
                    else        w_nxt_mcnt   = '0;
                end else begin
                    w_nxt_mcnt = r_mcnt + 16'd1;
                end
            end
            S_DOOR: begin
                if (w_hold)                     w_nxt_dcnt  = '0;
                else if (r_dcnt == c_DOOR_LAST) w_nxt_state = S_IDLE;
                else                            w_nxt_dcnt  = r_dcnt + 16'd1;
                // Late requests in an already-cleared class at this floor are
                // cleared too; the mask avoids re-pulsing a bit being cleared.
                if (w_nxt_state == S_DOOR) begin
                    w_nxt_pin = w_onehot & bus.active_in_levels & ~r_pin;
                    w_nxt_pup = w_onehot & bus.active_out_up_levels
                              & {BUTTONS_WIDTH{r_clr_up}} & ~r_pup;
                    w_nxt_pdn = w_onehot & bus.active_out_down_levels
                              & {BUTTONS_WIDTH{r_clr_dn}} & ~r_pdn;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
        if (w_enter_door) begin
            w_nxt_state  = S_DOOR;
            w_nxt_dcnt   = '0;
            w_nxt_dir    = w_entry_dir;
            w_nxt_clr_up = w_entry_clr_up;
            w_nxt_clr_dn = w_entry_clr_dn;
            w_nxt_pin    = w_onehot & bus.active_in_levels;
            w_nxt_pup    = w_onehot & bus.active_out_up_levels
                         & {BUTTONS_WIDTH{w_entry_clr_up}};
            w_nxt_pdn    = w_onehot & bus.active_out_down_levels
                         & {BUTTONS_WIDTH{w_entry_clr_dn}};
        end
    end

    // State and datapath registers; reset abandons any travel in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_floor  <= '0;
            r_dir    <= 1'b1;
            r_mcnt   <= '0;
            r_dcnt   <= '0;
            r_clr_up <= 1'b0;
            r_clr_dn <= 1'b0;
            r_pin    <= '0;
            r_pup    <= '0;
            r_pdn    <= '0;
        end else begin
            r_state  <= w_nxt_state;
            r_floor  <= w_nxt_floor;
            r_dir    <= w_nxt_dir;
            r_mcnt   <= w_nxt_mcnt;
            r_dcnt   <= w_nxt_dcnt;
            r_clr_up <= w_nxt_clr_up;
            r_clr_dn <= w_nxt_clr_dn;
            r_pin    <= w_nxt_pin;
            r_pup    <= w_nxt_pup;
            r_pdn    <= w_nxt_pdn;
        end
    end

    assign bus.current_floor              = r_floor;
    assign bus.direction                  = r_dir;
    assign bus.moving                     = (r_state == S_MOVING);
    assign bus.door_open                  = (r_state == S_DOOR);
    assign bus.inactivate_in_levels       = r_pin;
    assign bus.inactivate_out_up_levels   = r_pup;
    assign bus.inactivate_out_down_levels = r_pdn;

endmodule
`default_nettype wire

// File: tb/tb_floor_request_server.sv
`default_nettype none
// ============================================================================
// Module      : tb_floor_request_server
// Description : Directed scenarios plus random request traffic for the
//               collective car controller, checked cycle by cycle against a
//               behavioural elevator model. The bench also plays the button
//               latch: a pulsed clear removes the request at the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_floor_request_server;
    localparam int BW = 8;
    localparam int FB = 3;
    localparam int MC = 4;
    localparam int DC = 6;

    logic clk = 1'b0;
    logic reset;
    bit   tb_hold = 1'b0;
`ifdef DOOR_HOLD_EN
    logic door_hold;
`endif

    floor_request_server_if #(.BUTTONS_WIDTH(BW), .FLOOR_BITS(FB)) bus ();

    floor_request_server #(
        .BUTTONS_WIDTH(BW), .FLOOR_BITS(FB), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef DOOR_HOLD_EN
        .door_hold(door_hold),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Latched requests as held by the button latch.
    logic [BW-1:0] a_in = '0, a_up = '0, a_dn = '0;

    // Elevator model: 0 idle, 1 travelling, 2 door open; m_left = clocks left
    // in the current travel leg or door period.
    int            m_state, n_state;
    int            m_floor, n_floor;
    bit            m_dir, n_dir;
    int            m_left, n_left;
    bit            m_cu, n_cu, m_cd, n_cd;
    logic [BW-1:0] m_pin, n_pin, m_pup, n_pup, m_pdn, n_pdn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit req_at(int f);
        return a_in[f] | a_up[f] | a_dn[f];
    endfunction

    function automatic bit any_above(int f);
        for (int i = f + 1; i < BW; i++) if (req_at(i)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit any_below(int f);
        for (int i = 0; i < f; i++) if (req_at(i)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_floor = 0; m_dir = 1'b1; m_left = 0;
        m_cu = 1'b0; m_cd = 1'b0; m_pin = '0; m_pup = '0; m_pdn = '0;
    endtask

    task automatic model_eval();
        int f;
        bit arrive, ahead;
        n_state = m_state; n_floor = m_floor; n_dir = m_dir; n_left = m_left;
        n_cu = m_cu; n_cd = m_cd; n_pin = '0; n_pup = '0; n_pdn = '0;
        arrive = 1'b0;
        f = m_floor;
        case (m_state)
            0: begin
                if (req_at(f) && (a_in[f] || a_up[f] || a_dn[f])) arrive = 1'b1;
                else if (m_dir ? any_above(f) : any_below(f)) begin
                    n_state = 1; n_left = MC;
                end else if (any_above(f) || any_below(f)) begin
                    n_state = 1; n_left = MC; n_dir = !m_dir;
                end
            end
            1: begin
                if (m_left == 1) begin
                    f = m_dir ? m_floor + 1 : m_floor - 1;
                    n_floor = f;
                    if (f == 0 || f == BW - 1) arrive = 1'b1;
                    else if (m_dir && (a_in[f] || a_up[f] || (!any_above(f) && req_at(f)))) arrive = 1'b1;
                    else if (!m_dir && (a_in[f] || a_dn[f] || (!any_below(f) && req_at(f)))) arrive = 1'b1;
                    else n_left = MC;
                end else begin
                    n_left = m_left - 1;
                end
            end
            default: begin
                if (tb_hold) n_left = DC;
                else if (m_left == 1) n_state = 0;
                else n_left = m_left - 1;
                if (n_state == 2) begin
                    n_pin[f] = a_in[f] & !m_pin[f];
                    n_pup[f] = m_cu & a_up[f] & !m_pup[f];
                    n_pdn[f] = m_cd & a_dn[f] & !m_pdn[f];
                end
            end
        endcase
        if (arrive) begin
            ahead   = m_dir ? any_above(f) : any_below(f);
            n_state = 2;
            n_left  = DC;
            n_cu    = m_dir || !ahead;
            n_cd    = !m_dir || !ahead;
            n_dir   = (f == 0) ? 1'b1 : (f == BW - 1) ? 1'b0 : (ahead ? m_dir : !m_dir);
            n_pin   = '0; n_pup = '0; n_pdn = '0;
            n_pin[f] = a_in[f];
            n_pup[f] = n_cu & a_up[f];
            n_pdn[f] = n_cd & a_dn[f];
        end
    endtask

    task automatic check_all();
        chk("floor",    bus.current_floor, m_floor);
        chk("dir",      bus.direction, m_dir);
        chk("moving",   bus.moving, (m_state == 1));
        chk("door",     bus.door_open, (m_state == 2));
        chk("clr_in",   bus.inactivate_in_levels, m_pin);
        chk("clr_up",   bus.inactivate_out_up_levels, m_pup);
        chk("clr_down", bus.inactivate_out_down_levels, m_pdn);
    endtask

    // One clock: drive, predict, let the edge happen, retire latch clears.
    task automatic cycle();
        bus.active_in_levels       = a_in;
        bus.active_out_up_levels   = a_up;
        bus.active_out_down_levels = a_dn;
`ifdef DOOR_HOLD_EN
        door_hold = tb_hold;
`endif
        model_eval();
        @(posedge clk);
        @(negedge clk);
        a_in &= ~m_pin; a_up &= ~m_pup; a_dn &= ~m_pdn;
        m_state = n_state; m_floor = n_floor; m_dir = n_dir; m_left = n_left;
        m_cu = n_cu; m_cd = n_cd; m_pin = n_pin; m_pup = n_pup; m_pdn = n_pdn;
        check_all();
    endtask

    task automatic run_until(input int st, input int fl, input string tag);
        int k = 0;
        while (!(m_state == st && (fl < 0 || m_floor == fl)) && k < 300) begin
            cycle();
            k++;
        end
        chk(tag, (m_state == st && (fl < 0 || m_floor == fl)) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_floor"},  bus.current_floor, 0);
        chk({tag, "_dir"},    bus.direction, 1);
        chk({tag, "_moving"}, bus.moving, 0);
        chk({tag, "_door"},   bus.door_open, 0);
        chk({tag, "_clr_in"}, bus.inactivate_in_levels, 0);
        chk({tag, "_clr_up"}, bus.inactivate_out_up_levels, 0);
        chk({tag, "_clr_dn"}, bus.inactivate_out_down_levels, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.active_in_levels = '0; bus.active_out_up_levels = '0; bus.active_out_down_levels = '0;
`ifdef DOOR_HOLD_EN
        door_hold = 1'b0;
`endif
        model_reset();
        @(negedge clk); @(negedge clk);
        chk_reset_values("rst");
        reset = 1'b0;
        cycle();

        // S1: request at the standing floor -> door, single clear pulse.
        a_in[0] = 1'b1;
        cycle();
        chk("s1_pulse", bus.inactivate_in_levels, 8'h01);
        chk("s1_door",  bus.door_open, 1);
        cycle();
        chk("s1_pulse_end", bus.inactivate_in_levels, 8'h00);
        repeat (4) cycle();
        chk("s1_door_last", bus.door_open, 1);
        cycle();
        chk("s1_door_closed", bus.door_open, 0);
        chk("s1_floor", bus.current_floor, 0);

        // S2: travel 0 -> 3, one floor per MC clocks, turn round at the end.
        a_in[3] = 1'b1;
        cycle();
        chk("s2_moving", bus.moving, 1);
        repeat (3) cycle();
        chk("s2_floor0", bus.current_floor, 0);
        cycle();
        chk("s2_floor1", bus.current_floor, 1);
        repeat (4) cycle();
        chk("s2_floor2", bus.current_floor, 2);
        repeat (4) cycle();
        chk("s2_floor3", bus.current_floor, 3);
        chk("s2_pulse",  bus.inactivate_in_levels, 8'h08);
        chk("s2_dir",    bus.direction, 0);
        chk("s2_door",   bus.door_open, 1);
        run_until(0, 3, "s2_idle");

        a_in[0] = 1'b1;
        run_until(2, 0, "ret_arrive");
        chk("ret_dir", bus.direction, 1);
        run_until(0, 0, "ret_idle");

        // S3: pass a down-call on the way up, serve it on the way back.
        a_dn[2] = 1'b1; a_in[5] = 1'b1;
        run_until(1, 2, "s3_at2");
        chk("s3_pass_moving", bus.moving, 1);
        chk("s3_pass_door",   bus.door_open, 0);
        run_until(2, -1, "s3_stop5");
        chk("s3_floor5",  bus.current_floor, 5);
        chk("s3_pulse5",  bus.inactivate_in_levels, 8'h20);
        chk("s3_dir5",    bus.direction, 0);
        run_until(2, 2, "s3_stop2");
        chk("s3_pulse2",  bus.inactivate_out_down_levels, 8'h04);
        run_until(0, 2, "s3_idle");

        // S4: hall-up call appears exactly on the arrival clock at floor 4.
        a_in[6] = 1'b1;
        run_until(1, 3, "s4_at3");
        repeat (MC - 1) cycle();
        a_up[4] = 1'b1;
        cycle();
        chk("s4_floor",  bus.current_floor, 4);
        chk("s4_door",   bus.door_open, 1);
        chk("s4_pulse",  bus.inactivate_out_up_levels, 8'h10);
        run_until(2, 6, "s4_stop6");
        chk("s4_dir6", bus.direction, 0);
        run_until(0, 6, "s4_idle");

        // S5: asynchronous reset while travelling between floors 3 and 2.
        a_in[0] = 1'b1;
        run_until(1, 3, "s5_at3");
        cycle();
        #2 reset = 1'b1;
        #1;
        chk_reset_values("s5_async");
        @(negedge clk); @(negedge clk);
        chk_reset_values("s5_held");
        reset = 1'b0;
        model_reset();
        cycle();
        chk("s5_resume_door",  bus.door_open, 1);
        chk("s5_resume_pulse", bus.inactivate_in_levels, 8'h01);
        run_until(0, 0, "s5_idle");

`ifdef DOOR_HOLD_EN
        // S6: door hold keeps the door open, release restarts the full count.
        a_in[1] = 1'b1;
        run_until(2, 1, "s6_door");
        tb_hold = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("s6_held", bus.door_open, 1);
        end
        tb_hold = 1'b0;
        repeat (5) begin
            cycle();
            chk("s6_release", bus.door_open, 1);
        end
        cycle();
        chk("s6_closed", bus.door_open, 0);
`endif

        // Random traffic: presses in all classes, occasional external drops.
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                int b;
                b = int'($urandom_range(0, BW - 1));
                case ($urandom_range(0, 2))
                    0:       a_in[b] = 1'b1;
                    1:       a_up[b] = 1'b1;
                    default: a_dn[b] = 1'b1;
                endcase
            end
            if ($urandom_range(0, 63) == 0) a_in[$urandom_range(0, BW - 1)] = 1'b0;
            if ($urandom_range(0, 63) == 0) a_dn[$urandom_range(0, BW - 1)] = 1'b0;
`ifdef DOOR_HOLD_EN
            tb_hold = ($urandom_range(0, 15) == 0);
`endif
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
